// File: rtl/systolic_seq_pkg.sv
// systolic_seq_pkg: sequencer state/command types and the drain-length helper.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_CLEAR,
        OP_LOAD_W,
        OP_COMPUTE,
        OP_ILLEGAL
    } cmd_op_t;

    // Zero beats needed to push the last skewed operand through an n x n array.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// skew_line: per-lane operand skew; lane i delays its input by i shift enables.
module skew_line #(
    parameter int LANES = 8,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [LANES*W-1:0] din,
    output logic [LANES*W-1:0] dout
);

    assign dout[W-1:0] = din[W-1:0];

    for (genvar i = 1; i < LANES; i++) begin : g_lane
        logic [i*W-1:0] sr_q, sr_d, sr_shift;
        if (i == 1) begin : g_one
            assign sr_shift = din[i*W +: W];
        end else begin : g_many
            assign sr_shift = {sr_q[(i-1)*W-1:0], din[i*W +: W]};
        end
        always_comb sr_d = clr ? '0 : en ? sr_shift : sr_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) sr_q <= '0;
            else        sr_q <= sr_d;
        end
        assign dout[i*W +: W] = sr_q[i*W-1 -: W];
    end

endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: command-driven clear/load/stream/drain controller for a systolic cluster.
// Define SYSTOLIC_SEQ_PERF_EN to build the busy/stall performance counters.
module systolic_sequencer
    import systolic_seq_pkg::*;
#(
    parameter int DATA_BITS  = 16,
    parameter int ARRAY_SIZE = 8,
    parameter int NUM_ARRAYS = 8,
    parameter int LEN_BITS   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [$clog2(NUM_ARRAYS)-1:0]   cmd_array,
    input  logic                            cmd_broadcast,
    input  logic [LEN_BITS-1:0]             cmd_len,
    output logic                            cmd_done,
    output logic                            cmd_err,
    output logic                            busy,
    input  logic                            op_valid,
    output logic                            op_ready,
    input  logic [ARRAY_SIZE*DATA_BITS-1:0] op_a,
    input  logic [ARRAY_SIZE*DATA_BITS-1:0] op_b,
    input  logic                            cluster_ready,
    output logic [$clog2(NUM_ARRAYS)-1:0]   array_select,
    output logic                            clear_acc,
    output logic                            load_weights,
    output logic                            compute_enable,
    output logic                            broadcast_mode,
    output logic [ARRAY_SIZE*DATA_BITS-1:0] a_inputs,
    output logic [ARRAY_SIZE*DATA_BITS-1:0] b_inputs,
    output logic [31:0]                     perf_busy_cycles,
    output logic [31:0]                     perf_stall_cycles
);

    localparam int VW = ARRAY_SIZE * DATA_BITS;
    localparam int AW = $clog2(NUM_ARRAYS);
    localparam logic [LEN_BITS-1:0] DRAIN_LAST = LEN_BITS'(drain_cycles(ARRAY_SIZE));
    localparam logic [LEN_BITS-1:0] LOAD_LAST  = LEN_BITS'(ARRAY_SIZE - 1);

    seq_state_t          state_q, state_d;
    cmd_op_t             op_q, op_d;
    logic [LEN_BITS-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [AW-1:0]       array_select_q, array_select_d;
    logic                broadcast_mode_q, broadcast_mode_d;
    logic                cmd_ready_q, cmd_ready_d, cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d;
    logic                busy_q, busy_d, op_ready_q, op_ready_d;
    logic                clear_acc_q, clear_acc_d, load_weights_q, load_weights_d;
    logic                compute_enable_q, compute_enable_d;
    logic [VW-1:0]       a_inputs_q, a_inputs_d, b_inputs_q, b_inputs_d;
    logic [VW-1:0]       a_din, b_din, a_skew, b_skew;
    logic                beat, skew_clr, skew_en;

    // Drain pushes zeros behind the last real beat.
    assign a_din = (state_q == S_DRAIN) ? '0 : op_a;
    assign b_din = (state_q == S_DRAIN) ? '0 : op_b;
    assign beat  = op_valid && op_ready_q;

    skew_line #(.LANES(ARRAY_SIZE), .W(DATA_BITS)) u_skew_a (
        .clk(clk), .reset(reset), .clr(skew_clr), .en(skew_en), .din(a_din), .dout(a_skew)
    );

    skew_line #(.LANES(ARRAY_SIZE), .W(DATA_BITS)) u_skew_b (
        .clk(clk), .reset(reset), .clr(skew_clr), .en(skew_en), .din(b_din), .dout(b_skew)
    );

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        array_select_d   = array_select_q;
        broadcast_mode_d = broadcast_mode_q;
        a_inputs_d       = a_inputs_q;
        b_inputs_d       = b_inputs_q;
        skew_clr         = 1'b0;
        skew_en          = 1'b0;
        load_weights_d   = 1'b0;
        compute_enable_d = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid && cmd_ready_q) begin
                op_d             = cmd_op_t'(cmd_op);
                len_d            = cmd_len;
                cnt_d            = '0;
                array_select_d   = cmd_array;
                broadcast_mode_d = cmd_broadcast;
                state_d = (op_d == OP_CLEAR)  ? S_CLEAR :
                          (op_d == OP_LOAD_W) ? S_LOAD  :
                          (op_d == OP_COMPUTE && cmd_len != '0) ? S_STREAM : S_DONE;
                if (state_d == S_STREAM) begin
                    skew_clr   = 1'b1;
                    a_inputs_d = '0;
                    b_inputs_d = '0;
                end
            end
            S_CLEAR: state_d = S_DONE;
            S_LOAD: if (beat) begin
                load_weights_d = 1'b1;
                b_inputs_d     = op_b;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LOAD_LAST) state_d = S_DONE;
            end
            S_STREAM: if (beat) begin
                skew_en          = 1'b1;
                compute_enable_d = 1'b1;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == len_q - LEN_BITS'(1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: if (cnt_q != DRAIN_LAST) begin
                skew_en          = 1'b1;
                compute_enable_d = 1'b1;
                cnt_d            = cnt_q + 1'b1;
            end else if (cluster_ready) begin
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (skew_en) begin
            a_inputs_d = a_skew;
            b_inputs_d = b_skew;
        end
        cmd_ready_d = state_d == S_IDLE;
        busy_d      = state_d != S_IDLE;
        op_ready_d  = state_d == S_LOAD || state_d == S_STREAM;
        clear_acc_d = state_d == S_CLEAR;
        cmd_done_d  = state_d == S_DONE;
        cmd_err_d   = state_d == S_DONE && op_d == OP_ILLEGAL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            op_q             <= OP_CLEAR;
            len_q            <= '0;
            cnt_q            <= '0;
            array_select_q   <= '0;
            broadcast_mode_q <= 1'b0;
            cmd_ready_q      <= 1'b0;
            cmd_done_q       <= 1'b0;
            cmd_err_q        <= 1'b0;
            busy_q           <= 1'b0;
            op_ready_q       <= 1'b0;
            clear_acc_q      <= 1'b0;
            load_weights_q   <= 1'b0;
            compute_enable_q <= 1'b0;
            a_inputs_q       <= '0;
            b_inputs_q       <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            len_q            <= len_d;
            cnt_q            <= cnt_d;
            array_select_q   <= array_select_d;
            broadcast_mode_q <= broadcast_mode_d;
            cmd_ready_q      <= cmd_ready_d;
            cmd_done_q       <= cmd_done_d;
            cmd_err_q        <= cmd_err_d;
            busy_q           <= busy_d;
            op_ready_q       <= op_ready_d;
            clear_acc_q      <= clear_acc_d;
            load_weights_q   <= load_weights_d;
            compute_enable_q <= compute_enable_d;
            a_inputs_q       <= a_inputs_d;
            b_inputs_q       <= b_inputs_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign cmd_done       = cmd_done_q;
    assign cmd_err        = cmd_err_q;
    assign busy           = busy_q;
    assign op_ready       = op_ready_q;
    assign array_select   = array_select_q;
    assign broadcast_mode = broadcast_mode_q;
    assign clear_acc      = clear_acc_q;
    assign load_weights   = load_weights_q;
    assign compute_enable = compute_enable_q;
    assign a_inputs       = a_inputs_q;
    assign b_inputs       = b_inputs_q;

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = (busy_q && perf_busy_q != '1) ? perf_busy_q + 32'd1 : perf_busy_q;
        perf_stall_d = ((state_q == S_LOAD || state_q == S_STREAM) && !op_valid && perf_stall_q != '1)
                       ? perf_stall_q + 32'd1 : perf_stall_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_busy_cycles  = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed checks of clear, load, compute/drain, illegal op and reset.
module tb_systolic_sequencer;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [2:0]    cmd_array = '0;
    logic          cmd_broadcast = 1'b0;
    logic [7:0]    cmd_len = '0;
    logic          cmd_done, cmd_err, busy;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [VW-1:0] op_a = '0;
    logic [VW-1:0] op_b = '0;
    logic          cluster_ready = 1'b1;
    logic [2:0]    array_select;
    logic          clear_acc, load_weights, compute_enable, broadcast_mode;
    logic [VW-1:0] a_inputs, b_inputs;
    logic [31:0]   perf_busy_cycles, perf_stall_cycles;

    int total = 0;
    int bad = 0;
    int n_ce = 0;
    int n_clr = 0;
    int n_ld = 0;

    systolic_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_array(cmd_array), .cmd_broadcast(cmd_broadcast), .cmd_len(cmd_len),
        .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .cluster_ready(cluster_ready), .array_select(array_select),
        .clear_acc(clear_acc), .load_weights(load_weights),
        .compute_enable(compute_enable), .broadcast_mode(broadcast_mode),
        .a_inputs(a_inputs), .b_inputs(b_inputs),
        .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_ce  += int'(compute_enable);
        n_clr += int'(clear_acc);
        n_ld  += int'(load_weights);
    end

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] arr, input logic bc, input logic [7:0] len);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("cmd_ready_wait", VW'(cmd_ready), VW'(1));
        cmd_op = op; cmd_array = arr; cmd_broadcast = bc; cmd_len = len;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_compute(input int len, input int hold);
        int k = 0;
        int adv = 0;
        int w = 0;
        int steps = 0;
        int kk;
        int exp_adv;
        logic beat;
        logic [VW-1:0] ea, eb;
        exp_adv = (len == 0) ? 0 : len + 2 * N - 1;
        cluster_ready = (hold == 0);
        send_cmd(2'd2, 3'd3, 1'b1, 8'(len));
        check("bcast", VW'(broadcast_mode), VW'(1));
        check("asel_cmp", VW'(array_select), VW'(3));
        while (!cmd_done && steps < 400) begin
            op_valid = (k < len);
            op_a = {N{16'(16'h0100 * (k + 1))}};
            for (int i = 0; i < N; i++) op_b[i*DW +: DW] = 16'(16'h0010 * (k + 1) + i);
            if (adv == exp_adv) begin
                if (w >= hold) cluster_ready = 1'b1;
                w++;
            end
            beat = op_valid && op_ready;
            @(posedge clk); #1;
            steps++;
            if (beat) k++;
            if (compute_enable) begin
                adv++;
                for (int i = 0; i < N; i++) begin
                    kk = adv - i - 1;
                    ea[i*DW +: DW] = (kk >= 0 && kk < len) ? 16'(16'h0100 * (kk + 1)) : 16'h0;
                    eb[i*DW +: DW] = (kk >= 0 && kk < len) ? 16'(16'h0010 * (kk + 1) + i) : 16'h0;
                end
                check("skew_a", a_inputs, ea);
                check("skew_b", b_inputs, eb);
            end
        end
        op_valid = 1'b0;
        check("ce_pulses", VW'(adv), VW'(exp_adv));
        check("cmp_done", VW'(cmd_done), VW'(1));
        check("cmp_err", VW'(cmd_err), VW'(0));
        if (len != 0) check("cr_wait", VW'(w), VW'(hold + 1));
        @(posedge clk); #1;
        check("cmp_done_pulse", VW'(cmd_done), VW'(0));
        cluster_ready = 1'b1;
    endtask

    initial begin
        int c;
        int loads;
        int c_ce, c_clr, c_ld;
        logic beat;
        logic [VW-1:0] bv;

        // reset state
        #3;
        check("rst_ready", VW'(cmd_ready), '0);
        check("rst_busy", VW'(busy), '0);
        check("rst_a", a_inputs, '0);
        check("rst_perf", VW'(perf_busy_cycles), '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", VW'(cmd_ready), VW'(1));

        // CLEAR array 5
        c_clr = n_clr;
        send_cmd(2'd0, 3'd5, 1'b0, 8'd0);
        check("clr_asel", VW'(array_select), VW'(5));
        check("clr_acc", VW'(clear_acc), VW'(1));
        check("clr_early_done", VW'(cmd_done), VW'(0));
        @(posedge clk); #1;
        check("clr_acc_off", VW'(clear_acc), VW'(0));
        check("clr_done", VW'(cmd_done), VW'(1));
        check("clr_err", VW'(cmd_err), VW'(0));
        @(posedge clk); #1;
        check("clr_done_pulse", VW'(cmd_done), VW'(0));
        check("clr_pulses", VW'(n_clr - c_clr), VW'(1));

        // LOAD_W with op_valid low every other cycle
        send_cmd(2'd1, 3'd2, 1'b0, 8'd0);
        check("ld_ordy", VW'(op_ready), VW'(1));
        loads = 0;
        c = 0;
        while (!cmd_done && c < 40) begin
            op_valid = (c % 2 == 0);
            op_b = {N{16'h1000 + 16'(c)}};
            beat = op_valid && op_ready;
            bv = op_b;
            @(posedge clk); #1;
            check("ld_we", VW'(load_weights), VW'(beat));
            if (beat) check("ld_b", b_inputs, bv);
            loads += int'(load_weights);
            c++;
        end
        op_valid = 1'b0;
        check("ld_count", VW'(loads), VW'(8));
        check("ld_done", VW'(cmd_done), VW'(1));
        @(posedge clk); #1;
        check("ld_done_pulse", VW'(cmd_done), VW'(0));
        check("ld_ordy_off", VW'(op_ready), VW'(0));

        // COMPUTE len=4, cluster ready; then with cluster_ready held low 10 cycles
        do_compute(4, 0);
        do_compute(4, 10);

        // illegal op: done+err, no cluster activity
        c_ce = n_ce; c_clr = n_clr; c_ld = n_ld;
        send_cmd(2'd3, 3'd1, 1'b0, 8'd0);
        check("ill_done", VW'(cmd_done), VW'(1));
        check("ill_err", VW'(cmd_err), VW'(1));
        @(posedge clk); #1;
        check("ill_done_pulse", VW'(cmd_done), VW'(0));
        check("ill_err_pulse", VW'(cmd_err), VW'(0));
        check("ill_quiet", VW'((n_ce - c_ce) + (n_clr - c_clr) + (n_ld - c_ld)), '0);

        // COMPUTE len=0: done with no compute_enable
        c_ce = n_ce;
        do_compute(0, 0);
        check("len0_ce", VW'(n_ce - c_ce), '0);

        // async reset in the middle of a len=6 stream
        cluster_ready = 1'b1;
        send_cmd(2'd2, 3'd2, 1'b0, 8'd6);
        for (int k = 0; k < 3; k++) begin
            op_valid = 1'b1;
            op_a = {N{16'h0700 + 16'(k)}};
            op_b = op_a;
            @(posedge clk); #1;
        end
        check("mid_ce", VW'(compute_enable), VW'(1));
        #2 reset = 1'b0;
        #1;
        check("mrst_ce", VW'(compute_enable), '0);
        check("mrst_a", a_inputs, '0);
        check("mrst_b", b_inputs, '0);
        check("mrst_busy", VW'(busy), '0);
        check("mrst_ordy", VW'(op_ready), '0);
        check("mrst_asel", VW'(array_select), '0);
        op_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_compute(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
- Command-driven controller that sequences one systolic_array_cluster per core: accumulator clear, weight load, skewed operand streaming, drain, completion.
- Sits between the core's control path (command port) and the cluster, replacing the core's tied-off systolic control regs.
- Operand vectors arrive on a valid/ready stream from the core's staging logic.
- Per-lane input skew (lane i delayed i beats) is generated here.

Parameters:
- DATA_BITS, 16, operand width (Q1.15)
- ARRAY_SIZE, 8, systolic dimension N
- NUM_ARRAYS, 8, arrays in cluster
- LEN_BITS, 8, width of the compute stream length

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, can accept
- cmd_op  in  2  0=CLEAR, 1=LOAD_W, 2=COMPUTE, 3=illegal
- cmd_array  in  $clog2(NUM_ARRAYS)  target array
- cmd_broadcast  in  1  drive all arrays
- cmd_len  in  LEN_BITS  COMPUTE beats
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  valid with cmd_done; illegal op
- busy  out  1  not IDLE
- op_valid  in  1  operand beat offered
- op_ready  out  1  beat accepted when both high
- op_a  in  N*DATA_BITS  A vector, lane i at [i*DATA_BITS +: DATA_BITS]
- op_b  in  N*DATA_BITS  B / weight vector
- cluster_ready  in  1  cluster ready flag for the selected array
- array_select  out  $clog2(NUM_ARRAYS)  to cluster
- clear_acc, load_weights, compute_enable, broadcast_mode  out  1 each  to cluster
- a_inputs, b_inputs  out  N*DATA_BITS  skewed operands to cluster
- perf_busy_cycles, perf_stall_cycles  out  32 each  see Optional Feature

Behaviour:
- All outputs are registered. On reset low (async), every output is 0 and state is IDLE; in-flight commands are discarded.
- States: IDLE, CLEAR, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch op/array/broadcast/len; array_select and broadcast_mode are updated next cycle and held until IDLE.
  - Next state: CLEAR, LOAD, or STREAM. Op 3 goes to DONE with cmd_err=1.
- CLEAR: clear_acc=1 for exactly one cycle, then DONE.
- LOAD:
  - op_ready=1. Each accepted beat gives load_weights=1 the next cycle, with b_inputs = op_b unskewed.
  - Cycles without a beat drive load_weights=0.
  - After N beats, go to DONE.
- STREAM:
  - op_ready=1. Each accepted beat shifts both skew lines; compute_enable=1 the following cycle.
  - No beat means no shift and compute_enable=0, so the array holds.
  - Lane i output presents beat k at the (k+i+1)-th advance.
  - After cmd_len beats, go to DRAIN. cmd_len=0 goes straight to DONE with no compute_enable.
- DRAIN:
  - Shift zeros every cycle for 2N-1 cycles; compute_enable=1 each cycle.
  - Then wait for cluster_ready=1, then DONE.
  - Total compute_enable pulses per COMPUTE = cmd_len + 2N-1.
- DONE: cmd_done=1 (and cmd_err if illegal) for one cycle, then IDLE. cmd_ready is 0 in DONE, so commands are never back-to-back within 2 cycles.
- op_ready=0 outside LOAD/STREAM; beats offered then are ignored.
- Skew lines are cleared when entering STREAM, so there is no carry-over between commands.
- Beat counter is LEN_BITS wide with no wrap: cmd_len=255 gives exactly 255 beats.

Optional Feature:
- Macro SYSTOLIC_SEQ_PERF_EN.
- Defined:
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts LOAD/STREAM cycles with op_valid=0.
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package systolic_seq_pkg holds:
  - seq_state_t enum
  - cmd_op_t enum (CLEAR, LOAD_W, COMPUTE, ILLEGAL)
  - DRAIN_CYCLES = 2*ARRAY_SIZE-1, as a function of N
- Sub-module skew_line (N lanes, lane i is an i-stage shift register, shared shift enable, synchronous clear), instantiated for A and B.

Test Plan:
- Reset asserted mid-STREAM (beat 3 of 6) -> all outputs 0 immediately, busy=0; next COMPUTE len=2 completes normally with no leftover data.
- CLEAR array 5 -> array_select=5, clear_acc high exactly 1 cycle, cmd_done 1 cycle later, cmd_err=0.
- LOAD_W, N=8, op_valid low every other cycle -> load_weights high exactly 8 cycles, never while stalled; cmd_done once.
- COMPUTE len=4, lane i of op_a = 16'h0100*(k+1) for beat k, cluster_ready=1 -> a_inputs[i] shows beat 0 at advance i+1; compute_enable pulses = 19; cmd_done once.
- COMPUTE len=4 with cluster_ready held 0 for 10 cycles after drain -> cmd_done delayed until cluster_ready rises, compute_enable=0 while waiting.
- cmd_op=3, then COMPUTE len=0 -> first gives cmd_done+cmd_err with no cluster activity; second gives cmd_done, cmd_err=0, zero compute_enable pulses.
